// File: rtl/op_sequencer_if.sv
// Purpose: command channel between a command source and op_sequencer.
// Latency: none, wires only.
// Backpressure: a command transfers on a clock edge where cmd_valid and cmd_ready are both high. The source holds the command until that edge.
//
// Signals:
//   cmd_valid  source -> sequencer  command present
//   cmd_ready  sequencer -> source  command FIFO has room and the block is out of reset
//   cmd_op     source -> sequencer  00 NOP, 01 LOADA, 10 LOADB, 11 EXEC
//   cmd_f      source -> sequencer  compute-unit function select for this command
//   cmd_r      source -> sequencer  router select for this command
interface op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_f;
  logic [1:0] cmd_r;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_f,
    output cmd_r,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_f,
    input  cmd_r,
    output cmd_ready
  );
endinterface

// File: rtl/op_sequencer.sv
// Purpose: sequences queued commands into Ld_A/Ld_B/Shift_En strobes and F/R selects for the 8-bit logic datapath.
// Latency: a command accepted into an idle, empty block is popped one edge later. Its first strobe appears in the cycle after the pop.
// Backpressure: cmd_ready is low while the DEPTH-entry FIFO is full or reset is asserted. An offer made while cmd_ready is low is not taken.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     synchronous, active-low reset
//   cmd         command channel (slave side of op_sequencer_if)
//   o_ld_a      load register A from Din
//   o_ld_b      load register B from Din
//   o_shift_en  shift both registers by one position
//   o_f         function select to the compute unit, held between commands
//   o_r         routing select to the router, held between commands
//   o_busy      high while the FSM is not in IDLE
//   o_done      one-cycle pulse when a command completes
//   o_count     current FIFO occupancy
module op_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  op_sequencer_if.slave              cmd,
  output logic                       o_ld_a,
  output logic                       o_ld_b,
  output logic                       o_shift_en,
  output logic [2:0]                 o_f,
  output logic [1:0]                 o_r,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOADA = 2'b01;
  localparam logic [1:0] OP_LOADB = 2'b10;
  localparam logic [1:0] OP_EXEC  = 2'b11;

  // ---------------------------------------------------------------
  // Command FIFO: circular buffer of {op, f, r} words.
  // ---------------------------------------------------------------
  logic [6:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [6:0]    w_head;
  logic [1:0]    w_head_op;
  logic [2:0]    w_head_f;
  logic [1:0]    w_head_r;

  // FSM and current-command registers.
  logic [1:0]    r_state;
  logic [1:0]    r_op;
  logic [2:0]    r_f;
  logic [1:0]    r_r;
  logic [SW-1:0] r_shift_cnt;

  // The pointers do not assume a power-of-two DEPTH, so the wrap is an explicit compare.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Ready comes from the registered count. A slot freed by a pop becomes visible one cycle after the pop.
  assign w_ready       = (r_count != CW'(DEPTH)) && i_reset;
  assign cmd.cmd_ready = w_ready;

  assign w_push = cmd.cmd_valid && w_ready;
  // Only IDLE pops. Reset blocks the pop so that a command cannot slip into the current-command register during reset.
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && i_reset;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[6:5];
  assign w_head_f  = w_head[4:2];
  assign w_head_r  = w_head[1:0];

  // The storage array needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd.cmd_op, cmd.cmd_f, cmd.cmd_r};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      // A push and a pop on the same edge cancel out in the count. Both pointers still advance.
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_f         <= '0;
      r_r         <= '0;
      r_shift_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            // F/R change only here, so the router and compute unit keep their configuration between commands.
            r_op <= w_head_op;
            r_f  <= w_head_f;
            r_r  <= w_head_r;
            unique case (w_head_op)
              OP_LOADA, OP_LOADB: r_state <= S_LOAD;
              OP_EXEC: begin
                r_state     <= S_SHIFT;
                r_shift_cnt <= '0;
              end
              default: r_state <= S_DONE;
            endcase
          end
        end
        S_LOAD: begin
          r_state <= S_DONE;
        end
        S_SHIFT: begin
          // The cycles with counts 0..WIDTH-1 give exactly WIDTH shift strobes.
          if (r_shift_cnt == SW'(WIDTH - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_shift_cnt <= r_shift_cnt + SW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Every strobe is decoded from registered state alone. There is no combinational path from cmd_* to the datapath.
  // The LOAD/SHIFT split keeps the strobes mutually exclusive.
  assign o_ld_a     = (r_state == S_LOAD) && (r_op == OP_LOADA);
  assign o_ld_b     = (r_state == S_LOAD) && (r_op == OP_LOADB);
  assign o_shift_en = (r_state == S_SHIFT);
  assign o_done     = (r_state == S_DONE);
  assign o_busy     = (r_state != S_IDLE);
  assign o_f        = r_f;
  assign o_r        = r_r;
  assign o_count    = r_count;

endmodule

// File: tb/tb_op_sequencer.sv
module tb_op_sequencer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDA  = 2'b01;
  localparam logic [1:0] OP_LDB  = 2'b10;
  localparam logic [1:0] OP_EXEC = 2'b11;

  // Kinds of observable output events.
  localparam logic [1:0] K_LDA = 2'd0;
  localparam logic [1:0] K_LDB = 2'd1;
  localparam logic [1:0] K_SH  = 2'd2;
  localparam logic [1:0] K_DN  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] f;
    logic [1:0] r;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_a, ld_b, shift_en, busy, done;
  logic [2:0] f;
  logic [1:0] r;
  logic [2:0] count;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  ev_t sbq[$];

  op_sequencer_if u_if();

  op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .cmd        (u_if),
    .o_ld_a     (ld_a),
    .o_ld_b     (ld_b),
    .o_shift_en (shift_en),
    .o_f        (f),
    .o_r        (r),
    .o_busy     (busy),
    .o_done     (done),
    .o_count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected output events for one command, in the order they must appear.
  function automatic void push_exp(input logic [1:0] op, input logic [2:0] cf, input logic [1:0] cr);
    ev_t e;
    e.f = cf;
    e.r = cr;
    case (op)
      OP_LDA: begin e.kind = K_LDA; sbq.push_back(e); end
      OP_LDB: begin e.kind = K_LDB; sbq.push_back(e); end
      OP_EXEC: begin
        e.kind = K_SH;
        for (int i = 0; i < WIDTH; i++) sbq.push_back(e);
      end
      default: ;
    endcase
    e.kind = K_DN;
    sbq.push_back(e);
  endfunction

  // Monitor: at every falling edge, any active strobe is matched against the scoreboard head.
  logic       prev_act  = 1'b0;
  logic [1:0] prev_kind = K_DN;
  always @(negedge clk) begin
    logic act;
    ev_t  obs;
    ev_t  exp;
    if (mon_en) begin
      act = ld_a | ld_b | shift_en | done;
      chk("busy_vs_activity", busy, act);
      if (prev_act && prev_kind == K_DN) chk("idle_cycle_after_done", act, 1'b0);
      if (prev_act && prev_kind != K_DN) chk("unbroken_burst", act, 1'b1);
      obs.kind = ld_a ? K_LDA : ld_b ? K_LDB : shift_en ? K_SH : K_DN;
      obs.f = f;
      obs.r = r;
      if (act) begin
        chk("strobe_onehot", $countones({ld_a, ld_b, shift_en, done}), 1);
        if (sbq.size() == 0) begin
          chk("unexpected_event", obs, 7'h7f);
        end else begin
          exp = sbq.pop_front();
          chk("event{kind,f,r}", obs, exp);
        end
      end
      prev_act  = act;
      prev_kind = obs.kind;
      if (!rst_n) prev_act = 1'b0;
    end
  end

  // Offer one command and hold it until accepted; valid is left high so that back-to-back sends stay contiguous.
  task automatic send(input logic [1:0] op, input logic [2:0] cf, input logic [1:0] cr, output int stalls);
    bit acc;
    acc    = 1'b0;
    stalls = 0;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_f     = cf;
    u_if.cmd_r     = cr;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (u_if.cmd_ready === 1'b1) begin
        acc = 1'b1;
        push_exp(op, cf, cr);
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_accept_timeout", acc, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b0 && count === 3'd0 && sbq.size() == 0) ok = 1'b1;
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s;
    bit  found;

    // ---- Reset with a command offered ----
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = OP_EXEC;
    u_if.cmd_f     = 3'd5;
    u_if.cmd_r     = 2'd2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", u_if.cmd_ready, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_strobes", {ld_a, ld_b, shift_en, done, busy}, 5'b0);
    chk("rst_f", f, 3'd0);
    chk("rst_r", r, 2'd0);
    u_if.cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", u_if.cmd_ready, 1'b1);
    @(posedge clk); #1;
    chk("count_after_rst", count, 3'd0);

    // ---- Load then execute ----
    send(OP_LDA, 3'd5, 2'd2, s);
    send(OP_LDB, 3'd6, 2'd1, s);
    send(OP_EXEC, 3'b010, 2'b01, s);
    u_if.cmd_valid = 1'b0;
    wait_idle("load_exec_drain");

    // ---- FIFO full ----
    for (int i = 0; i < 5; i++) send(OP_EXEC, 3'(i + 1), 2'(i), s);
    chk("full_count", count, 3'd4);
    chk("full_ready", u_if.cmd_ready, 1'b0);
    send(OP_EXEC, 3'd6, 2'd1, s);
    u_if.cmd_valid = 1'b0;
    chk("full_6th_stalls", s, 7);
    wait_idle("full_drain");

    // ---- Simultaneous push/pop with Count=1 ----
    send(OP_EXEC, 3'd4, 2'd3, s);
    send(OP_NOP, 3'd0, 2'd0, s);
    u_if.cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      found = 1'b0;
      for (int j = 0; j < 40 && !found; j++) begin
        if (busy === 1'b0 && count === 3'd1) found = 1'b1;
        else begin @(posedge clk); #1; end
      end
      chk("pp_idle_count1", found, 1'b1);
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = OP_NOP;
      u_if.cmd_f     = 3'(k + 1);
      u_if.cmd_r     = 2'(k);
      chk("pp_ready", u_if.cmd_ready, 1'b1);
      push_exp(OP_NOP, 3'(k + 1), 2'(k));
      @(posedge clk); #1;
      u_if.cmd_valid = 1'b0;
      chk("pp_count", count, 3'd1);
    end
    wait_idle("pp_drain");

    // ---- Reset mid-SHIFT with two commands queued ----
    send(OP_EXEC, 3'd5, 2'd1, s);
    send(OP_LDA, 3'd3, 2'd2, s);
    send(OP_EXEC, 3'd7, 2'd0, s);
    u_if.cmd_valid = 1'b0;
    chk("mid_queued", count, 3'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_4th_shift", shift_en, 1'b1);
    rst_n = 1'b0;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = OP_LDB;
    @(posedge clk); #1;
    sbq.delete();
    chk("mid_shift_off", shift_en, 1'b0);
    chk("mid_no_done", done, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_count", count, 3'd0);
    chk("mid_fr", {f, r}, 5'd0);
    @(posedge clk); #1;
    u_if.cmd_valid = 1'b0;
    rst_n = 1'b1;
    chk("mid_count_rst2", count, 3'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_nothing_ran_count", count, 3'd0);
    chk("mid_nothing_ran_busy", busy, 1'b0);

    // ---- NOP and F/R hold ----
    send(OP_EXEC, 3'd1, 2'd2, s);
    u_if.cmd_valid = 1'b0;
    wait_idle("exec_fr_drain");
    chk("hold_f_exec", f, 3'd1);
    chk("hold_r_exec", r, 2'd2);
    send(OP_NOP, 3'd7, 2'd3, s);
    u_if.cmd_valid = 1'b0;
    chk("nop_prepop_f", f, 3'd1);
    chk("nop_prepop_count", count, 3'd1);
    @(posedge clk); #1;
    chk("nop_done", done, 1'b1);
    chk("nop_no_strobes", {ld_a, ld_b, shift_en}, 3'b0);
    chk("nop_f", f, 3'd7);
    chk("nop_r", r, 2'd3);
    @(posedge clk); #1;
    chk("nop_done_gone", done, 1'b0);
    chk("nop_idle", busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("nop_hold_f", f, 3'd7);
    chk("nop_hold_r", r, 2'd3);

    @(negedge clk);
    mon_en = 1'b0;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/op_sequencer.md
# op_sequencer

Command-driven sequencer for the 8-bit logic processor datapath. It replaces push-button sequencing with a small command FIFO. Each accepted command is popped in order and drives the register unit's Ld_A/Ld_B/Shift_En strobes and the compute/router F/R selects for the correct number of cycles. It sits between a command source and the register_unit/compute/router instances, in place of the button-driven control unit.

## Interface
- WIDTH, 8: register width; number of Shift_En cycles per EXEC command.
- DEPTH, 4: command FIFO entries, at least 2.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Cmd_Valid  in  1  a command is presented.
- Cmd_Ready  out  1  FIFO can accept a command.
- Cmd_Op  in  2  opcode: 00 NOP, 01 LOADA, 10 LOADB, 11 EXEC.
- Cmd_F  in  3  function select carried with the command.
- Cmd_R  in  2  routing select carried with the command.
- Ld_A  out  1  load register A from Din.
- Ld_B  out  1  load register B from Din.
- Shift_En  out  1  shift both registers one position.
- F  out  3  function select to the compute unit.
- R  out  2  routing select to the router.
- Busy  out  1  a command is in progress (state is not IDLE).
- Done  out  1  one-cycle pulse when a command completes.
- Count  out  clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- **Accept:** a command is accepted on any edge where Cmd_Valid=1 and Cmd_Ready=1. The {Cmd_Op, Cmd_F, Cmd_R} word is written to the FIFO tail.
- **Ready:** Cmd_Ready = (Count != DEPTH) and Reset=1. An offer made while the FIFO is full is not accepted; the source must hold it.
- **FSM states:** IDLE, LOAD, SHIFT, DONE.
- **IDLE:** if Count > 0, pop the head into the current-command register. Next state depends on the opcode:
  - LOADA or LOADB -> LOAD.
  - EXEC -> SHIFT, with the shift counter cleared to 0.
  - NOP -> DONE.
  - If Count = 0, stay in IDLE.
- **LOAD:** Ld_A=1 for LOADA, or Ld_B=1 for LOADB, for exactly one cycle; then -> DONE.
- **SHIFT:** Shift_En=1 every cycle. The counter increments each cycle; when counter = WIDTH-1, go to DONE. This gives exactly WIDTH shift cycles.
- **DONE:** Done=1 for one cycle; then -> IDLE.
- **F/R outputs:** F and R are taken from the current-command register. They update only on a pop and hold their value after the command ends, until the next pop. The router and compute unit therefore keep a stable configuration.
- **Output decode:** Ld_A, Ld_B, Shift_En, Done and Busy are decoded from registered state only. There is no combinational path from the Cmd_* inputs to any datapath strobe.
- **Exclusivity:** at most one of Ld_A, Ld_B and Shift_En is high in any cycle.
- **FIFO:** circular buffer with wrapping head and tail pointers. A simultaneous push and pop leaves Count unchanged, and both operations take effect. A pop never occurs when Count = 0.
- **Reset (Reset=0 at an edge), from any state including mid-SHIFT:**
  - State -> IDLE; FIFO emptied; Count=0.
  - Shift counter=0; F=0; R=0.
  - Ld_A, Ld_B, Shift_En, Busy and Done are all 0 from the next cycle.
  - The command in progress is discarded, and no Done is issued for it.
  - Pushes offered during reset are ignored.

## Timing
- Cycle numbering: a command accepted at edge 0 into an empty, idle sequencer is popped at edge 1.
- LOADA/LOADB: Ld strobe in cycle 2, Done in cycle 3, IDLE in cycle 4. Total 3 cycles per command.
- EXEC: Shift_En in cycles 2 .. WIDTH+1, Done in cycle WIDTH+2. WIDTH+2 cycles per command (10 for WIDTH=8).
- NOP: Done in cycle 2.
- F and R are valid from cycle 2, i.e. in the first strobe cycle.
- Busy is high from cycle 2 through the Done cycle inclusive.
- Back-to-back commands: each command spends one IDLE cycle after DONE before the next pop.
- Cmd_Ready reflects the registered Count. It returns high in the cycle after a pop from a full FIFO.

## Test plan
- **Reset:** hold Reset=0 for 2 cycles with Cmd_Valid=1. Required: Cmd_Ready=0, Count=0, all strobes 0, F=0, R=0. After release, Cmd_Ready=1.
- **Load then execute:** push LOADA, LOADB, then EXEC with F=3'b010, R=2'b01. Required:
  - Ld_A pulse, then Done, then a gap.
  - Ld_B pulse, then Done.
  - Exactly 8 consecutive Shift_En cycles with F=010 and R=01, then a single Done.
  - Busy is never high together with Count reading stale.
- **FIFO full:** push 5 EXECs with Cmd_Valid held high (DEPTH=4). Required:
  - The 1st is popped, and 4 more fill the FIFO.
  - Cmd_Ready drops while Count=4.
  - The 6th offer is held until the next pop, then accepted.
  - All commands execute in order, with 10 cycles each.
- **Simultaneous push/pop:** with Count=1, push on the same edge as the IDLE pop. Required: Count stays 1, and the pointers wrap correctly across 10 such cycles.
- **Reset mid-SHIFT:** assert Reset=0 during the 4th Shift_En cycle with 2 commands queued. Required: Shift_En=0 on the next cycle, no Done, Count=0, and no queued command executes afterwards.
- **NOP and F/R hold:** push NOP with F=7, R=3 after an EXEC with F=1, R=2. Required: Done 1 cycle after the pop, no strobes, and F/R switch to 7/3 at the pop and hold while IDLE.
